// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and the lookahead carry function for the pipelined CLA adder
//   DEF_WIDTH, DEF_STAGES : default operand width and pipeline depth
//   CLA_MAX_SEG           : widest segment cla_carries can serve
//   cla_carries(p, g, cin): carry vector c[0..MAX], c[0]=cin, c[i+1]=g[i]|p[i]&c[i]
package cla_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_STAGES = 4;
   localparam int CLA_MAX_SEG = 64;
   // The recurrence is written iteratively but elaborates to flat sum-of-products per carry.
   function automatic logic [CLA_MAX_SEG:0] cla_carries(input logic [CLA_MAX_SEG-1:0] p, input logic [CLA_MAX_SEG-1:0] g, input logic cin);
      logic [CLA_MAX_SEG:0] c;
      c[0] = cin;
      for (int i = 0; i < CLA_MAX_SEG; i++) c[i+1] = g[i] | (p[i] & c[i]);
      return c;
   endfunction
endpackage

// File: rtl/cla_pipe_adder_seg.sv
// cla_seg: combinational SEG-bit carry-lookahead segment
//   a, b  : segment operand bits (b already conditioned for subtract)
//   cin   : carry into the segment LSB
//   sum   : segment sum bits
//   cout  : carry out of the segment MSB
//   c_msb : carry into the segment MSB (used for signed overflow)
module cla_seg
   import cla_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           c_msb
);
   logic [SEG-1:0] p, g;
   logic [CLA_MAX_SEG:0] c;
   logic unused_c;
   assign p = a ^ b;
   assign g = a & b;
   assign c = cla_carries(CLA_MAX_SEG'(p), CLA_MAX_SEG'(g), cin);
   assign sum = p ^ c[SEG-1:0];
   assign cout = c[SEG];
   assign c_msb = c[SEG-1];
   // carries above SEG are only the zero-padded tail of the shared function
   assign unused_c = ^c;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead add/sub with valid/ready stream and ovf/zero flags
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_ready is the pipe-advance signal
//   in_a, in_b            : operands
//   in_cin, in_sub        : carry in (add only), subtract select
//   out_valid/out_ready   : result handshake
//   out_sum, out_cout     : result and carry out of MSB (sub: 1 = no borrow)
//   out_ovf, out_zero     : signed overflow, result-is-zero
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);
   localparam int SEG = WIDTH / STAGES;
   if (WIDTH % STAGES != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be divisible by STAGES");
   end
   if (SEG > CLA_MAX_SEG) begin : g_bad_seg
      $error("cla_pipe_adder: segment wider than CLA_MAX_SEG");
   end
   // Slot k: x holds finished sum bits below (k+1)*SEG and raw A bits above; y holds B' bits.
   logic [STAGES-1:0] vld;
   logic [WIDTH-1:0] x [STAGES];
   logic [WIDTH-1:0] y [STAGES];
   logic cr [STAGES];
   logic ovf, zero, adv;
   logic [WIDTH-1:0] a_s [STAGES];
   logic [WIDTH-1:0] b_s [STAGES];
   logic c_s [STAGES];
   logic [WIDTH-1:0] nx [STAGES];
   logic [SEG-1:0] s_seg [STAGES];
   logic co [STAGES];
   logic cm [STAGES];
   assign adv = !vld[STAGES-1] | out_ready;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] M = WIDTH'({SEG{1'b1}}) << (k * SEG);
      if (k == 0) begin : g_first
         assign a_s[k] = in_a;
         assign b_s[k] = in_sub ? ~in_b : in_b;
         assign c_s[k] = in_sub | in_cin;
      end else begin : g_next
         assign a_s[k] = x[k-1];
         assign b_s[k] = y[k-1];
         assign c_s[k] = cr[k-1];
      end
      cla_seg #(.SEG(SEG)) u_seg (
         .a(a_s[k][k*SEG +: SEG]),
         .b(b_s[k][k*SEG +: SEG]),
         .cin(c_s[k]),
         .sum(s_seg[k]),
         .cout(co[k]),
         .c_msb(cm[k])
      );
      assign nx[k] = (a_s[k] & ~M) | (WIDTH'(s_seg[k]) << (k * SEG));
   end
   always_ff @(posedge clk)
      if (rst) begin
         vld <= '0;
         ovf <= 1'b0;
         zero <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            x[k] <= '0;
            y[k] <= '0;
            cr[k] <= 1'b0;
         end
      end else if (adv) begin
         vld <= STAGES'({vld, in_valid});
         ovf <= cm[STAGES-1] ^ co[STAGES-1];
         zero <= nx[STAGES-1] == '0;
         for (int k = 0; k < STAGES; k++) begin
            x[k] <= nx[k];
            y[k] <= b_s[k];
            cr[k] <= co[k];
         end
      end
   assign in_ready = adv;
   assign out_valid = vld[STAGES-1];
   assign out_sum = x[STAGES-1];
   assign out_cout = cr[STAGES-1];
   assign out_ovf = ovf;
   assign out_zero = zero;
endmodule
